data_mem_bridge: RTL

//  Load/store bridge between the core's memory-access stage and a Wishbone-classic data bus.

---
 rtl/osiris_pkg.sv | 31 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/data_mem_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/osiris_pkg.sv
// Shared load/store definitions: funct3 codes, access sizes and the bridge FSM encoding.
package osiris_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  // Unsupported funct3 encodings fall through to a word access.
  function automatic size_e access_size(logic [2:0] funct3);
    case (funct3)
      F3Lb, F3Lbu: return SzByte;
      F3Lh, F3Lhu: return SzHalf;
      default:     return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-selects/replication, misalignment check,
// and load extraction with sign/zero extension.
module lsu_align
  import osiris_pkg::*;
(
  input  logic [1:0]  st_addr_lo_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_sel_o,
  output logic [31:0] st_wdata_o,
  output logic        misaligned_o,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] ld_bus_dat_i,
  output logic [31:0] ld_rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    st_sel_o     = 4'b1111;
    st_wdata_o   = st_wdata_i;
    misaligned_o = 1'b0;
    case (access_size(st_funct3_i))
      SzByte: begin
        st_sel_o   = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SzHalf: begin
        st_sel_o     = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o   = {2{st_wdata_i[15:0]}};
        misaligned_o = st_addr_lo_i[0];
      end
      default: begin
        misaligned_o = |st_addr_lo_i;
      end
    endcase
  end

  always_comb begin
    ld_byte    = 8'(ld_bus_dat_i >> {ld_addr_lo_i, 3'b000});
    ld_half    = 16'(ld_bus_dat_i >> {ld_addr_lo_i[1], 4'b0000});
    ld_signed  = ~ld_funct3_i[2];
    ld_rdata_o = ld_bus_dat_i;
    case (access_size(ld_funct3_i))
      SzByte:  ld_rdata_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SzHalf:  ld_rdata_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_rdata_o = ld_bus_dat_i;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// MEM-stage load/store bridge to a single-beat Wishbone-classic data bus.
// Optional bus watchdog enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge
  import osiris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_wdata_M,
  input  logic                  i_we_M,
  input  logic                  i_re_M,
  input  logic [2:0]            i_funct3_M,
  output logic [DATA_WIDTH-1:0] o_rdata_M,
  output logic                  o_rvalid_M,
  output logic                  o_busy,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [DATA_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  output logic [3:0]            o_wb_sel,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]            sel_q, sel_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;

  logic                  req;
  logic                  misaligned;
  logic                  timeout;
  logic [3:0]            st_sel;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_rdata;

  lsu_align u_align (
    .st_addr_lo_i (i_addr_M[1:0]),
    .st_funct3_i  (i_funct3_M),
    .st_wdata_i   (i_wdata_M),
    .st_sel_o     (st_sel),
    .st_wdata_o   (st_wdata),
    .misaligned_o (misaligned),
    .ld_addr_lo_i (addr_lo_q),
    .ld_funct3_i  (funct3_q),
    .ld_bus_dat_i (i_wb_dat),
    .ld_rdata_o   (ld_rdata)
  );

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero outside REQ, so it is already clear on entry.
  assign cnt_d   = (state_q == StReq) ? cnt_q + CntW'(1) : '0;
  assign timeout = (state_q == StReq) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign req = i_we_M | i_re_M;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mis_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req && misaligned) begin
          mis_d = 1'b1;
        end else if (req) begin
          state_d   = StReq;
          adr_d     = {i_addr_M[DATA_WIDTH-1:2], 2'b00};
          dat_d     = st_wdata;
          sel_d     = st_sel;
          funct3_d  = i_funct3_M;
          addr_lo_d = i_addr_M[1:0];
          we_d      = i_we_M;  // store wins when both requests are high
          cyc_d     = 1'b1;
        end
      end
      StReq: begin
        // Priority: error, then acknowledge, then watchdog.
        if (i_wb_err || i_wb_ack || timeout) begin
          state_d = StDone;
          cyc_d   = 1'b0;
          err_d   = i_wb_err || !i_wb_ack;
          rdata_d = (i_wb_err || !i_wb_ack || we_q) ? '0 : ld_rdata;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      mis_q     <= mis_d;
    end
  end

  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = cyc_q;
  assign o_wb_we      = we_q;
  assign o_wb_adr     = adr_q;
  assign o_wb_dat     = dat_q;
  assign o_wb_sel     = sel_q;
  assign o_rvalid_M   = (state_q == StDone);
  assign o_bus_err    = (state_q == StDone) && err_q;
  assign o_rdata_M    = (state_q == StDone) ? rdata_q : '0;
  assign o_misaligned = mis_q;
  // Reset gates the combinational term so busy drops as soon as rst rises.
  assign o_busy = !rst && (((state_q == StIdle) && req && !misaligned) || (state_q == StReq));

endmodule
